campo_asteroides: RTL

Parametrised asteroid field engine. Holds a table of N asteroid slots: position, direction opcode and valid bit. On each `iniciar` pulse it runs an autonomous sweep that moves every live asteroid one step, frees asteroids that leave the field (or wraps them), detects collision with the ship and loads one new asteroid into the first free slot. It sits between the game control unit and the VGA/matrix renderer. It replaces the fixed 16×4-bit external-FSM asteroid datapath.

---
 rtl/campo_asteroides.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/campo_asteroides.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | campo_asteroides                                                         |
// | Asteroid field engine: slot table swept once per iniciar (move, free or  |
// | wrap, ship collision, single spawn) with an independent renderer port.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module campo_asteroides #(
   parameter int N_ASTE = 16,
   parameter int ADDR_W = 4,
   parameter int COOR_W = 4,
   parameter int WRAP   = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              gerar,
   input  logic [COOR_W-1:0] gerar_x,
   input  logic [COOR_W-1:0] gerar_y,
   input  logic [1:0]        gerar_opcode,
   input  logic [COOR_W-1:0] nave_x,
   input  logic [COOR_W-1:0] nave_y,
   input  logic              destruir,
   input  logic [ADDR_W-1:0] destruir_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COOR_W-1:0] rd_x,
   output logic [COOR_W-1:0] rd_y,
   output logic [1:0]        rd_opcode,
   output logic              rd_valido,
   output logic              ocupado,
   output logic              pronto,
   output logic              colisao,
   output logic [ADDR_W-1:0] colisao_addr,
   output logic              gerar_falhou,
   output logic [ADDR_W:0]   num_ativos
);

   localparam logic [ADDR_W:0] C_N_ASTE = (ADDR_W+1)'(N_ASTE);
   localparam logic [ADDR_W:0] C_ULTIMO = (ADDR_W+1)'(N_ASTE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LER      = 2'd1,
      ATUALIZA = 2'd2,
      FIM      = 2'd3
   } estado_t;

   estado_t r_estado, w_prox;

   logic [COOR_W-1:0] r_x  [N_ASTE];
   logic [COOR_W-1:0] r_y  [N_ASTE];
   logic [1:0]        r_op [N_ASTE];
   logic [N_ASTE-1:0] r_valido;

   logic [ADDR_W-1:0] r_ptr;
   logic              r_pend;
   logic [COOR_W-1:0] r_gx, r_gy, r_nave_x, r_nave_y;
   logic [1:0]        r_gop;
   logic [COOR_W-1:0] r_wx, r_wy;
   logic [1:0]        r_wop;
   logic              r_wv;

   logic [COOR_W:0]   w_nx, w_ny;
   logic              w_sai, w_acerto, w_ultimo, w_dest_ok, w_rd_ok;
   logic [ADDR_W:0]   w_cont;

   assign w_ultimo  = ({1'b0, r_ptr} == C_ULTIMO);
   assign w_dest_ok = ({1'b0, destruir_addr} < C_N_ASTE);
   assign w_rd_ok   = ({1'b0, rd_addr} < C_N_ASTE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_estado <= IDLE;
      else       r_estado <= w_prox;
   end

   always_comb begin
      w_prox  = r_estado;
      ocupado = 1'b1;
      pronto  = 1'b0;
      case (r_estado)
         IDLE: begin
            ocupado = 1'b0;
            if (iniciar) w_prox = LER;
         end
         LER:      w_prox = ATUALIZA;
         ATUALIZA: w_prox = w_ultimo ? FIM : LER;
         FIM: begin
            pronto = 1'b1;
            w_prox = IDLE;
         end
         default:  w_prox = IDLE;
      endcase
   end

   // One step in COOR_W+1 bits: the extra bit flags carry/borrow out of the field
   always_comb begin
      w_nx = {1'b0, r_wx};
      w_ny = {1'b0, r_wy};
      case (r_wop)
         2'b00:   w_nx = {1'b0, r_wx} + (COOR_W+1)'(1);
         2'b01:   w_nx = {1'b0, r_wx} - (COOR_W+1)'(1);
         2'b10:   w_ny = {1'b0, r_wy} + (COOR_W+1)'(1);
         default: w_ny = {1'b0, r_wy} - (COOR_W+1)'(1);
      endcase
      w_sai    = w_nx[COOR_W] | w_ny[COOR_W];
      w_acerto = (w_nx[COOR_W-1:0] == r_nave_x) && (w_ny[COOR_W-1:0] == r_nave_y);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ASTE; i++) begin
            r_x[i]  <= '0;
            r_y[i]  <= '0;
            r_op[i] <= '0;
         end
         r_valido     <= '0;
         r_ptr        <= '0;
         r_pend       <= 1'b0;
         r_gx         <= '0;
         r_gy         <= '0;
         r_gop        <= '0;
         r_nave_x     <= '0;
         r_nave_y     <= '0;
         r_wx         <= '0;
         r_wy         <= '0;
         r_wop        <= '0;
         r_wv         <= 1'b0;
         colisao      <= 1'b0;
         colisao_addr <= '0;
         gerar_falhou <= 1'b0;
      end else begin
         case (r_estado)
            IDLE: begin
               if (destruir && w_dest_ok) r_valido[destruir_addr] <= 1'b0;
               if (iniciar) begin
                  r_pend       <= gerar;
                  r_gx         <= gerar_x;
                  r_gy         <= gerar_y;
                  r_gop        <= gerar_opcode;
                  r_nave_x     <= nave_x;
                  r_nave_y     <= nave_y;
                  r_ptr        <= '0;
                  colisao      <= 1'b0;
                  colisao_addr <= '0;
                  gerar_falhou <= 1'b0;
               end
            end
            LER: begin
               r_wx  <= r_x[r_ptr];
               r_wy  <= r_y[r_ptr];
               r_wop <= r_op[r_ptr];
               r_wv  <= r_valido[r_ptr];
            end
            ATUALIZA: begin
               if (r_wv) begin
                  if (WRAP == 0 && w_sai) begin
                     r_valido[r_ptr] <= 1'b0;
                  end else if (w_acerto) begin
                     r_valido[r_ptr] <= 1'b0;
                     colisao         <= 1'b1;
                     if (!colisao) colisao_addr <= r_ptr;
                  end else begin
                     r_x[r_ptr] <= w_nx[COOR_W-1:0];
                     r_y[r_ptr] <= w_ny[COOR_W-1:0];
                  end
               end else if (r_pend) begin
                  r_x[r_ptr]      <= r_gx;
                  r_y[r_ptr]      <= r_gy;
                  r_op[r_ptr]     <= r_gop;
                  r_valido[r_ptr] <= 1'b1;
                  r_pend          <= 1'b0;
               end
               // Resolved on the last slot so the flag is already visible with pronto
               if (w_ultimo) gerar_falhou <= r_pend & r_wv;
               else          r_ptr <= r_ptr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_cont = '0;
      for (int i = 0; i < N_ASTE; i++) w_cont = w_cont + (ADDR_W+1)'(r_valido[i]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         num_ativos <= '0;
         rd_x       <= '0;
         rd_y       <= '0;
         rd_opcode  <= '0;
         rd_valido  <= 1'b0;
      end else begin
         num_ativos <= w_cont;
         if (w_rd_ok) begin
            rd_x      <= r_x[rd_addr];
            rd_y      <= r_y[rd_addr];
            rd_opcode <= r_op[rd_addr];
            rd_valido <= r_valido[rd_addr];
         end else begin
            rd_x      <= '0;
            rd_y      <= '0;
            rd_opcode <= '0;
            rd_valido <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
